axis_i2c_arbiter: RTL

AXIS_I2C_ARBITER -- requirements
Module: axis_i2c_arbiter

---
 rtl/axis_i2c_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/axis_i2c_arbiter.sv
`default_nettype none
//============================================================================
// Module      : axis_i2c_arbiter
// Description : Round-robin arbiter that lets N_REQ AXI-Stream requesters
//               share a single axis_i2c_master. Each command goes out
//               through the shared command stream. A read command also
//               holds the grant until the read byte has been returned to
//               the requester that issued it, or until a read timeout.
//               Read data that arrives while no read is outstanding is
//               discarded.
// Revision    : 1.0 - initial release
//============================================================================
module axis_i2c_arbiter #(
    parameter int N_REQ           = 4,
    parameter int AXIS_DATA_WIDTH = 16,
    parameter int I2C_DATA_WIDTH  = 8,
    parameter int RD_TIMEOUT      = 65535
) (
    input  logic                               clk_i,
    input  logic                               arstn_i,
    // requester command streams
    input  logic [N_REQ*AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [N_REQ-1:0]                   s_axis_tvalid,
    output logic [N_REQ-1:0]                   s_axis_tready,
    // command stream to the I2C master
    output logic [AXIS_DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    // read data from the I2C master
    input  logic [I2C_DATA_WIDTH-1:0]          s_rd_tdata,
    input  logic                               s_rd_tvalid,
    output logic                               s_rd_tready,
    // read data back to the requesters
    output logic [I2C_DATA_WIDTH-1:0]          m_rd_tdata,
    output logic [N_REQ-1:0]                   m_rd_tvalid,
    input  logic [N_REQ-1:0]                   m_rd_tready,
    // status
    output logic [$clog2(N_REQ)-1:0]           grant_o,
    output logic                               busy_o,
    output logic                               timeout_o,
    output logic                               drop_o
);

    localparam int c_gw     = $clog2(N_REQ);
    localparam int c_tw     = $clog2(RD_TIMEOUT + 1);
    localparam int c_rw_bit = 8;

    localparam logic [c_tw-1:0] c_tmo_last = c_tw'(RD_TIMEOUT - 1);
    localparam logic [c_gw-1:0] c_gnt_rst  = c_gw'(N_REQ - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_send = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;

    logic [1:0]                 r_state;
    logic [c_gw-1:0]            r_grant;
    logic [c_gw-1:0]            r_last_grant;
    logic [c_tw-1:0]            r_tmo_cnt;
    logic                       r_timeout;
    logic                       r_drop;

    logic [AXIS_DATA_WIDTH-1:0] w_cmd [N_REQ];
    logic [c_gw-1:0]            w_pick;
    logic                       w_any;
    logic                       w_in_send;
    logic                       w_in_wait;
    logic                       w_cmd_hs;
    logic                       w_rd_hs;
    logic                       w_tmo_hit;

    assign w_in_send = (r_state == c_st_send);
    assign w_in_wait = (r_state == c_st_wait);

    // Per-requester slicing and grant-qualified handshake steering
    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_req
            localparam logic [c_gw-1:0] c_idx = c_gw'(i);

            assign w_cmd[i]         = s_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
            assign s_axis_tready[i] = w_in_send && (r_grant == c_idx) && m_axis_tready;
            assign m_rd_tvalid[i]   = w_in_wait && (r_grant == c_idx) && s_rd_tvalid;
        end
    endgenerate

    // Command path: only the granted requester reaches the master, and only in SEND
    assign m_axis_tdata  = w_cmd[r_grant];
    assign m_axis_tvalid = w_in_send && s_axis_tvalid[r_grant];
    assign w_cmd_hs      = m_axis_tvalid && m_axis_tready;

    // Read return path: outside WAIT_RD the master is always accepted so stray data drains
    assign m_rd_tdata  = s_rd_tdata;
    assign s_rd_tready = w_in_wait ? m_rd_tready[r_grant] : 1'b1;
    assign w_rd_hs     = w_in_wait && s_rd_tvalid && m_rd_tready[r_grant];

    // A read handshake on the last allowed cycle takes priority over the timeout
    assign w_tmo_hit = w_in_wait && !w_rd_hs && (r_tmo_cnt == c_tmo_last);

    assign grant_o   = r_grant;
    assign busy_o    = (r_state != c_st_idle);
    assign timeout_o = r_timeout;
    assign drop_o    = r_drop;

    // Round-robin search: the first valid requester after last_grant, wrapping around
    always_comb begin
        logic [c_gw-1:0] w_idx;
        w_idx  = '0;
        w_pick = r_last_grant;
        w_any  = 1'b0;
        // Walk from the farthest candidate down so the nearest one is written last
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = c_gw'((int'(r_last_grant) + k) % N_REQ);
            if (s_axis_tvalid[w_idx]) begin
                w_pick = w_idx;
                w_any  = 1'b1;
            end
        end
    end

    // Main state machine with grant and round-robin pointer
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state      <= c_st_idle;
            r_grant      <= '0;
            r_last_grant <= c_gnt_rst;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_any) begin
                        r_grant <= w_pick;
                        r_state <= c_st_send;
                    end
                end
                c_st_send: begin
                    if (w_cmd_hs) begin
                        r_last_grant <= r_grant;
                        r_state      <= m_axis_tdata[c_rw_bit] ? c_st_wait : c_st_idle;
                    end
                end
                c_st_wait: begin
                    if (w_rd_hs || w_tmo_hit) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Read timeout counter: cleared when a read command is accepted, counts in WAIT_RD
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_tmo_cnt <= '0;
        end else if (w_cmd_hs) begin
            r_tmo_cnt <= '0;
        end else if (w_in_wait) begin
            r_tmo_cnt <= r_tmo_cnt + c_tw'(1);
        end
    end

    // Single-cycle status pulses for read timeout and discarded stray read data
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_timeout <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_timeout <= w_tmo_hit;
            r_drop    <= !w_in_wait && s_rd_tvalid;
        end
    end

endmodule
`default_nettype wire
